// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding and defaults for the iterative divider.
// Revision 1.0
`default_nettype none

package div_ctrl_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

endpackage : div_ctrl_pkg

`default_nettype wire

// File: rtl/div_ctrl_step.sv
// div_ctrl_step: one combinational restoring shift-subtract iteration.
// Revision 1.0
`default_nettype none

module div_ctrl_step
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // rem < divisor holds between steps, so one extra bit covers the shifted value
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign fits    = ~diff[WIDTH];
  assign rem_nxt = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], fits};

endmodule : div_ctrl_step

`default_nettype wire

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU controller with HI/LO write strobe and EX stall.
// Revision 1.0
`default_nettype none

module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall_req,
  output logic             ready,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             q_neg, r_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_abs, b_abs, lo_fix, hi_fix;

  assign b_zero = (b == '0);
  assign a_abs  = (signed_div & a[WIDTH-1]) ? -a : a;
  assign b_abs  = (signed_div & b[WIDTH-1]) ? -b : b;
  assign lo_fix = q_neg ? -quo_nxt : quo_nxt;
  assign hi_fix = r_neg ? -rem_nxt : rem_nxt;

  div_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    ready     = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          state_nxt = b_zero ? DIV_ZERO : DIV_ON;
        end
      end
      DIV_ON: begin
        stall_req = 1'b1;
        if (cnt == LAST) state_nxt = DIV_END;
      end
      DIV_ZERO: begin
        stall_req = 1'b1;
        state_nxt = DIV_END;
      end
      DIV_END: begin
        ready     = 1'b1;
        hilo_we   = 1'b1;
        state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
    // A cancelled EX instruction must neither stall nor write HI/LO
    if (annul) begin
      state_nxt = DIV_IDLE;
      stall_req = 1'b0;
      ready     = 1'b0;
      hilo_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && !annul && !b_zero) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= a_abs;
            divisor <= b_abs;
            q_neg   <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg   <= signed_div & a[WIDTH-1];
          end
        end
        DIV_ON: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          // Result is captured on the final step so hi/lo are valid throughout END
          if (cnt == LAST && !annul) begin
            lo <= lo_fix;
            hi <= hi_fix;
          end
        end
        DIV_ZERO: begin
          if (!annul) begin
            lo <= '0;
            hi <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : div_ctrl

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed self-checking bench for div_ctrl.
// Revision 1.0
`default_nettype none

module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall_req;
  logic        ready;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .stall_req  (stall_req),
    .ready      (ready),
    .hilo_we    (hilo_we),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the IDLE cycle after END.
  task automatic do_div(input string tag, input logic sd, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] lo_e,
                        input logic [31:0] hi_e, input int lat);
    int n;
    bit stall_ok;
    bit early_we;
    start = 1'b1; signed_div = sd; a = av; b = bv;
    #1;
    chk({tag, "_stall_T"}, 32'(stall_req), 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 1; stall_ok = 1'b1; early_we = 1'b0;
    while (!ready && n < 40) begin
      if (!stall_req) stall_ok = 1'b0;
      if (hilo_we)    early_we = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
    chk({tag, "_no_early_we"}, 32'(early_we), 32'd0);
    chk({tag, "_we_end"}, 32'(hilo_we), 32'd1);
    chk({tag, "_stall_end"}, 32'(stall_req), 32'd0);
    chk({tag, "_lo"}, lo, lo_e);
    chk({tag, "_hi"}, hi, hi_e);
    @(negedge clk);
    chk({tag, "_we_one_cycle"}, 32'(hilo_we), 32'd0);
    chk({tag, "_ready_one_cycle"}, 32'(ready), 32'd0);
    chk({tag, "_lo_hold"}, lo, lo_e);
  endtask

  initial begin
    bit saw_we;
    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_we", 32'(hilo_we), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    resetn = 1'b1;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    do_div("divz", 1'b0, 32'd1234, 32'd0, 32'd0, 32'd0, 2);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    do_div("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);

    // Annul in the middle of a divide: no write, old hi/lo survive
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul_stall_same_cycle", 32'(stall_req), 32'd0);
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul_idle_stall", 32'(stall_req), 32'd0);
    saw_we = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we) saw_we = 1'b1;
    end
    chk("annul_no_we", 32'(saw_we), 32'd0);
    chk("annul_lo_kept", lo, 32'hFFFF_FFFD);
    chk("annul_hi_kept", hi, 32'd1);
    do_div("post_annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    // Back-to-back: second start in the IDLE cycle right after the first END
    do_div("b2b_first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    do_div("b2b_second", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Reset in the middle of a divide
    start = 1'b1; signed_div = 1'b1; a = 32'd500; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 32'(stall_req), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    resetn = 1'b1;
    saw_we = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we) saw_we = 1'b1;
    end
    chk("midrst_no_we", 32'(saw_we), 32'd0);
    do_div("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_ctrl

`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle divide controller and iterative datapath for DIV/DIVU, sitting in the EX stage beside alu.
- Accepts an operand pair from EX and asserts a stall request while it works.
- Runs a 32-iteration restoring shift-subtract.
- Presents quotient/remainder for the HI/LO write with a one-cycle write strobe.
- Shares the HI/LO write port with alu's mult results. EX-stage mux selects div_ctrl outputs when hilo_we=1.

Parameters:
- WIDTH, 32, operand/result width; ITER = WIDTH iterations.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  synchronous active-low reset
- start  input  1  EX holds a valid DIV/DIVU (decoded from `EXE_DIV_OP/`EXE_DIVU_OP)
- signed_div  input  1  1=DIV (signed), 0=DIVU
- a  input  WIDTH  dividend (rs)
- b  input  WIDTH  divisor (rt)
- annul  input  1  flush/exception cancel of the EX instruction
- stall_req  output  1  EX stall request to hazard unit
- ready  output  1  result valid this cycle
- hilo_we  output  1  HI/LO write strobe
- hi  output  WIDTH  remainder
- lo  output  WIDTH  quotient

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE; iteration counter=0; internal regs=0; hi=lo=0; ready=hilo_we=0. stall_req=0 (combinational on state, so 0 during reset).
- States: IDLE, DIVZERO, ON, END. 2-bit encoding.
- IDLE:
  - start=1 & annul=0 & b!=0: latch |a|, |b| (absolute values when signed_div, raw otherwise), quotient sign = a[31]^b[31], remainder sign = a[31]. Counter=0, go to ON.
  - start=1 & annul=0 & b==0: go to DIVZERO.
  - Otherwise stay in IDLE.
- ON: one restoring step per cycle. Shift {rem,quo} left 1, trial-subtract divisor, set quo LSB. Counter++. After the 32nd step (counter==31 at edge) go to END.
- DIVZERO: one cycle, then END with quotient=0, remainder=0.
- END:
  - ready=1, hilo_we=1.
  - lo = sign-corrected quotient (two's-complement negate when quotient sign=1 & signed_div).
  - hi = sign-corrected remainder (negate when remainder sign=1 & signed_div).
  - Next state IDLE unconditionally.
- stall_req (combinational) = (IDLE & start & ~annul) | ON | DIVZERO. 0 in END so the pipeline advances on the result cycle.
- Latency: start seen in cycle T → ON T+1..T+32 → END T+33 (ready, stall released). Divide-by-zero: DIVZERO T+1, END T+2.
- hi/lo are registered and hold their value after END until the next END. ready/hilo_we are high only in END.
- Overflow case 0x80000000 / -1 (signed): quotient wraps to 0x80000000, remainder 0. No exception.
- annul:
  - In any state, annul=1 forces next state IDLE.
  - Suppresses hilo_we and ready in the same cycle (END & annul → no write).
  - Gates stall_req to 0 in the same cycle.
- start is ignored outside IDLE. EX holds operands stable under stall, but datapath uses only latched copies.
- Back-to-back divides: a new start is accepted in the IDLE cycle following END. No bubble is required beyond that.
- Reset mid-operation: returns to IDLE at that edge. No write strobe.

Decomposition:
- defines2.vh gains DIV state encodings (`DIV_IDLE, `DIV_ON, `DIV_ZERO, `DIV_END) and keeps `EXE_DIV_OP/`EXE_DIVU_OP as the op decode source.
- One sub-module is natural: div_step, the combinational single shift-subtract iteration (inputs rem, quo, divisor; outputs next rem, quo).
- div_ctrl holds the FSM, counter, abs/sign-fix logic and output registers.

Test Plan:
- DIVU a=100, b=7, start 1 cycle → stall_req high T..T+32; ready/hilo_we at T+33 with lo=14, hi=2.
- DIV a=0xFFFFFFF9 (−7), b=2 → at T+33: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=7, b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU same operands → lo=0, hi=0x80000000.
- b=0 with a=1234 → END at T+2, lo=0, hi=0, hilo_we=1 for one cycle, stall_req high T..T+1.
- Start DIVU 100/7, assert annul at T+10 → stall_req 0 that cycle; IDLE at T+11; no hilo_we ever. Previous hi/lo unchanged. Next start yields correct result.
- resetn=0 at T+5 of a divide → IDLE, hi=lo=0, no hilo_we. Two back-to-back divides (100/7 then 9/3) → second lo=3, hi=0 at 34 cycles after first END.
